// File: rtl/spi_ctrl_pkg.sv
// Shared types and constants for the SPI frame controller.
// Holds the FSM state enum, default address window and the pointer-advance rule.
package spi_ctrl_pkg;

  typedef enum logic [1:0] {
    ADDR = 2'd0,
    DATA = 2'd1,
    ERR  = 2'd2
  } state_t;

  localparam int   DEF_FIRST_ADDR = 1;
  localparam int   DEF_MAX_ADDR   = 59;
  localparam logic RW_WRITE       = 1'b1;

  // Auto-increment with wrap back to the first valid register.
  function automatic logic [7:0] next_ptr(input logic [7:0] ptr,
                                          input logic [7:0] first,
                                          input logic [7:0] last);
    return (ptr == last) ? first : ptr + 8'd1;
  endfunction

endpackage

// File: rtl/spi_byte_shifter.sv
// Serial-to-parallel byte assembler, MSB first.
// o_byte presents the full byte combinationally on the edge that samples bit 7.
module spi_byte_shifter (
  input  logic       sclk,
  input  logic       rstn,
  input  logic       i_serial,
  output logic [7:0] o_byte,
  output logic       o_byte_done
);

  logic [6:0] r_shift;
  logic [2:0] r_cnt;

  always_ff @(posedge sclk or negedge rstn) begin
    if (!rstn) begin
      r_shift <= '0;
      r_cnt   <= '0;
    end else begin
      r_shift <= {r_shift[5:0], i_serial};
      r_cnt   <= r_cnt + 3'd1;
    end
  end

  // The eighth bit is still on the wire, so splice it in directly.
  assign o_byte      = {r_shift, i_serial};
  assign o_byte_done = (r_cnt == 3'd7);

endmodule

// File: rtl/spi_frame_ctrl.sv
// SPI register-access frame controller: address byte, then an endless
// auto-incrementing burst of writes or readout loads until reset.
module spi_frame_ctrl
  import spi_ctrl_pkg::*;
#(
  parameter int FIRST_ADDR = DEF_FIRST_ADDR,
  parameter int MAX_ADDR   = DEF_MAX_ADDR
) (
  input  logic       sclk,
  input  logic       rstn,
  input  logic       serial_in,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       wr_strobe,
  output logic [7:0] rd_addr,
  output logic       rd_load,
  output logic       msg_flag,
  output logic       addr_err
);

  localparam logic [7:0] FIRST8 = 8'(FIRST_ADDR);
  localparam logic [7:0] MAX8   = 8'(MAX_ADDR);

  state_t     r_state;
  state_t     w_next_state;
  logic [7:0] w_byte;
  logic       w_byte_done;
  logic [7:0] w_start;
  logic       w_addr_ok;
  logic [7:0] r_ptr;
  logic       r_rw;
  logic [7:0] r_wr_addr;
  logic [7:0] r_wr_data;
  logic       r_wr_strobe;
  logic [7:0] r_rd_addr;
  logic       r_rd_load;

  spi_byte_shifter u_shifter (
    .sclk        (sclk),
    .rstn        (rstn),
    .i_serial    (serial_in),
    .o_byte      (w_byte),
    .o_byte_done (w_byte_done)
  );

  assign w_start   = {1'b0, w_byte[6:0]};
  assign w_addr_ok = (w_start >= FIRST8) && (w_start <= MAX8);

  always_ff @(posedge sclk or negedge rstn) begin
    if (!rstn) r_state <= ADDR;
    else       r_state <= w_next_state;
  end

  // Only the address byte can move the FSM; DATA and ERR are left by reset alone.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ADDR:    if (w_byte_done) w_next_state = w_addr_ok ? DATA : ERR;
      DATA:    w_next_state = DATA;
      ERR:     w_next_state = ERR;
      default: w_next_state = ADDR;
    endcase
  end

  always_ff @(posedge sclk or negedge rstn) begin
    if (!rstn) begin
      r_ptr       <= '0;
      r_rw        <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_wr_strobe <= 1'b0;
      r_rd_addr   <= '0;
      r_rd_load   <= 1'b0;
    end else begin
      r_wr_strobe <= 1'b0;
      r_rd_load   <= 1'b0;
      if (w_byte_done) begin
        case (r_state)
          ADDR: begin
            if (w_addr_ok) begin
              r_rw <= w_byte[7];
              // A read preloads the start register immediately.
              if (w_byte[7] == RW_WRITE) begin
                r_ptr <= w_start;
              end else begin
                r_rd_addr <= w_start;
                r_rd_load <= 1'b1;
                r_ptr     <= next_ptr(w_start, FIRST8, MAX8);
              end
            end
          end
          DATA: begin
            if (r_rw == RW_WRITE) begin
              r_wr_addr   <= r_ptr;
              r_wr_data   <= w_byte;
              r_wr_strobe <= 1'b1;
            end else begin
              r_rd_addr <= r_ptr;
              r_rd_load <= 1'b1;
            end
            r_ptr <= next_ptr(r_ptr, FIRST8, MAX8);
          end
          default: ;
        endcase
      end
    end
  end

  assign wr_addr   = r_wr_addr;
  assign wr_data   = r_wr_data;
  assign wr_strobe = r_wr_strobe;
  assign rd_addr   = r_rd_addr;
  assign rd_load   = r_rd_load;
  assign msg_flag  = (r_state == DATA);
  assign addr_err  = (r_state == ERR);

  a_strobe_excl : assert property (@(posedge sclk) disable iff (!rstn)
                                   !(r_wr_strobe && r_rd_load));

endmodule

// File: tb/tb_spi_frame_ctrl.sv
// Self-checking bench for spi_frame_ctrl: frame-level model compared every cycle,
// plus literal expectations for each directed scenario.
module tb_spi_frame_ctrl;

  localparam int FIRST = 1;
  localparam int MAX   = 59;

  logic       sclk = 1'b0;
  logic       rstn = 1'b0;
  logic       serial_in = 1'b0;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       wr_strobe;
  logic [7:0] rd_addr;
  logic       rd_load;
  logic       msg_flag;
  logic       addr_err;

  int checks = 0;
  int errors = 0;

  logic [15:0] wrLog[$];
  logic [7:0]  rdLog[$];

  // Frame-level model state; mode 0 = awaiting address, 1 = write, 2 = read, 3 = bad
  int         mBits = 0;
  logic [7:0] mAcc = '0;
  int         mStart = 0;
  int         mMode = 0;
  logic [7:0] eWrAddr = '0;
  logic [7:0] eWrData = '0;
  logic       eWrStrobe = 1'b0;
  logic [7:0] eRdAddr = '0;
  logic       eRdLoad = 1'b0;
  logic       eMsg = 1'b0;
  logic       eErr = 1'b0;

  spi_frame_ctrl #(.FIRST_ADDR(FIRST), .MAX_ADDR(MAX)) dut (
    .sclk      (sclk),
    .rstn      (rstn),
    .serial_in (serial_in),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_strobe (wr_strobe),
    .rd_addr   (rd_addr),
    .rd_load   (rd_load),
    .msg_flag  (msg_flag),
    .addr_err  (addr_err)
  );

  always #5 sclk = ~sclk;

  function automatic int wrapAddr(input int s, input int n);
    return FIRST + ((s - FIRST + n) % (MAX - FIRST + 1));
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the n-th complete byte of a frame targets start + (n-1) for writes, start + n for reads.
  initial forever begin
    @(posedge sclk or negedge rstn);
    if (!rstn) begin
      mBits = 0; mAcc = '0; mStart = 0; mMode = 0;
      eWrAddr = '0; eWrData = '0; eWrStrobe = 1'b0;
      eRdAddr = '0; eRdLoad = 1'b0; eMsg = 1'b0; eErr = 1'b0;
    end else begin
      eWrStrobe = 1'b0;
      eRdLoad   = 1'b0;
      mAcc  = {mAcc[6:0], serial_in};
      mBits = mBits + 1;
      if (mBits % 8 == 0) begin
        if (mBits == 8) begin
          mStart = int'(mAcc[6:0]);
          if (mStart >= FIRST && mStart <= MAX) begin
            eMsg = 1'b1;
            if (mAcc[7]) mMode = 1;
            else begin
              mMode   = 2;
              eRdLoad = 1'b1;
              eRdAddr = 8'(wrapAddr(mStart, 0));
            end
          end else begin
            mMode = 3;
            eErr  = 1'b1;
          end
        end else if (mMode == 1) begin
          eWrStrobe = 1'b1;
          eWrAddr   = 8'(wrapAddr(mStart, mBits / 8 - 2));
          eWrData   = mAcc;
        end else if (mMode == 2) begin
          eRdLoad = 1'b1;
          eRdAddr = 8'(wrapAddr(mStart, mBits / 8 - 1));
        end
      end
    end
  end

  initial forever begin
    @(negedge sclk);
    checkOutput("wr_strobe", 32'(wr_strobe), 32'(eWrStrobe));
    checkOutput("wr_addr",   32'(wr_addr),   32'(eWrAddr));
    checkOutput("wr_data",   32'(wr_data),   32'(eWrData));
    checkOutput("rd_load",   32'(rd_load),   32'(eRdLoad));
    checkOutput("rd_addr",   32'(rd_addr),   32'(eRdAddr));
    checkOutput("msg_flag",  32'(msg_flag),  32'(eMsg));
    checkOutput("addr_err",  32'(addr_err),  32'(eErr));
    checkOutput("strobe_excl", 32'(wr_strobe & rd_load), 32'd0);
    if (wr_strobe === 1'b1) wrLog.push_back({wr_addr, wr_data});
    if (rd_load === 1'b1)   rdLog.push_back(rd_addr);
  end

  task automatic applyStimulus(input logic [7:0] b, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      serial_in = b[7 - i];
      @(negedge sclk);
    end
  endtask

  task automatic idleBits(input int n);
    repeat (n) begin
      serial_in = 1'b0;
      @(negedge sclk);
    end
  endtask

  task automatic doReset();
    #2 rstn = 1'b0;
    repeat (2) @(negedge sclk);
    rstn = 1'b1;
    wrLog.delete();
    rdLog.delete();
  endtask

  task automatic checkWr(input string name, input int idx, input logic [7:0] a, input logic [7:0] d);
    logic [15:0] act;
    act = 'x;
    if (idx < wrLog.size()) act = wrLog[idx];
    checkOutput(name, 32'(act), 32'({a, d}));
  endtask

  task automatic checkRd(input string name, input int idx, input logic [7:0] a);
    logic [7:0] act;
    act = 'x;
    if (idx < rdLog.size()) act = rdLog[idx];
    checkOutput(name, 32'(act), 32'(a));
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_wr_addr"},   32'(wr_addr),   32'd0);
    checkOutput({tag, "_wr_data"},   32'(wr_data),   32'd0);
    checkOutput({tag, "_wr_strobe"}, 32'(wr_strobe), 32'd0);
    checkOutput({tag, "_rd_addr"},   32'(rd_addr),   32'd0);
    checkOutput({tag, "_rd_load"},   32'(rd_load),   32'd0);
    checkOutput({tag, "_msg_flag"},  32'(msg_flag),  32'd0);
    checkOutput({tag, "_addr_err"},  32'(addr_err),  32'd0);
  endtask

  initial begin
    #3 checkAllZero("reset");
    @(negedge sclk);
    doReset();

    // Write burst from address 4
    applyStimulus(8'h84, 8);
    applyStimulus(8'hA5, 8);
    applyStimulus(8'h3C, 8);
    idleBits(2);
    checkOutput("wb_count", 32'(wrLog.size()), 32'd2);
    checkWr("wb_first", 0, 8'd4, 8'hA5);
    checkWr("wb_second", 1, 8'd5, 8'h3C);
    checkOutput("wb_rd_count", 32'(rdLog.size()), 32'd0);
    checkOutput("wb_msg", 32'(msg_flag), 32'd1);

    // Wrap from the top register back to the first
    doReset();
    applyStimulus(8'hBB, 8);
    applyStimulus(8'h11, 8);
    applyStimulus(8'h22, 8);
    idleBits(2);
    checkOutput("wrap_count", 32'(wrLog.size()), 32'd2);
    checkWr("wrap_59", 0, 8'd59, 8'h11);
    checkWr("wrap_1", 1, 8'd1, 8'h22);

    // Read burst from address 2
    doReset();
    applyStimulus(8'h02, 8);
    idleBits(17);
    checkOutput("rd_count", 32'(rdLog.size()), 32'd3);
    checkRd("rd_2", 0, 8'd2);
    checkRd("rd_3", 1, 8'd3);
    checkRd("rd_4", 2, 8'd4);
    checkOutput("rd_wr_count", 32'(wrLog.size()), 32'd0);

    // Address 0 rejected
    doReset();
    applyStimulus(8'h80, 8);
    applyStimulus(8'hFF, 8);
    idleBits(1);
    checkOutput("bad0_err", 32'(addr_err), 32'd1);
    checkOutput("bad0_msg", 32'(msg_flag), 32'd0);
    checkOutput("bad0_strobes", 32'(wrLog.size() + rdLog.size()), 32'd0);

    // Address 60 rejected
    doReset();
    applyStimulus(8'h3C, 8);
    applyStimulus(8'hFF, 8);
    applyStimulus(8'hFF, 8);
    idleBits(1);
    checkOutput("bad60_err", 32'(addr_err), 32'd1);
    checkOutput("bad60_msg", 32'(msg_flag), 32'd0);
    checkOutput("bad60_strobes", 32'(wrLog.size() + rdLog.size()), 32'd0);

    // Reset in the middle of a data byte
    doReset();
    applyStimulus(8'h85, 8);
    applyStimulus(8'hA0, 4);
    checkOutput("mid_msg_before", 32'(msg_flag), 32'd1);
    #2 rstn = 1'b0;
    #1 checkAllZero("mid");
    repeat (2) @(negedge sclk);
    rstn = 1'b1;
    wrLog.delete();
    rdLog.delete();
    applyStimulus(8'h81, 8);
    applyStimulus(8'h55, 8);
    idleBits(2);
    checkOutput("mid_count", 32'(wrLog.size()), 32'd1);
    checkWr("mid_write", 0, 8'd1, 8'h55);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/spi_frame_ctrl.md
SPI_FRAME_CTRL -- requirements
Module: spi_frame_ctrl

Interface
REQ-001 Parameter FIRST_ADDR, default 1: lowest valid register address and the auto-increment wrap target.
REQ-002 Parameter MAX_ADDR, default 59: highest valid register address (last analog byte).
REQ-003 sclk  input  1  serial clock; all state updates on posedge.
REQ-004 rstn  input  1  reset, asynchronous, active-low.
REQ-005 serial_in  input  1  serial data, MSB first, sampled on posedge sclk.
REQ-006 wr_addr  output  8  address of the completed write byte.
REQ-007 wr_data  output  8  completed write byte.
REQ-008 wr_strobe  output  1  one-cycle write pulse; wr_addr/wr_data valid while high.
REQ-009 rd_addr  output  8  address to load into the readout shifter.
REQ-010 rd_load  output  1  one-cycle pulse commanding the readout load of rd_addr.
REQ-011 msg_flag  output  1  high while a frame is in the DATA phase.
REQ-012 addr_err  output  1  sticky flag for an out-of-range start address.

Function
REQ-013 The FSM SHALL have states ADDR, DATA and ERR, and SHALL enter ADDR on reset.
REQ-014 A 3-bit bit counter SHALL count sampled bits 0..7; byte_done SHALL be the edge that samples bit 7; the counter SHALL then wrap to 0.
REQ-015 ADDR byte format: bit7 is rw (1=write, 0=read); bits6:0 are start_addr, zero-extended to 8 bits.
REQ-016 ADDR byte_done with FIRST_ADDR <= start_addr <= MAX_ADDR: latch rw; set ptr=start_addr; go to DATA; set msg_flag=1 on the same edge.
REQ-017 ADDR byte_done with start_addr outside that range: go to ERR; set addr_err=1; msg_flag stays 0.
REQ-018 ERR SHALL ignore serial_in and never assert wr_strobe or rd_load; only rstn exits ERR.
REQ-019 DATA write, each byte_done: register wr_data=byte and wr_addr=ptr; assert wr_strobe for exactly the next sclk cycle; then advance ptr.
REQ-020 DATA read, on the ADDR byte_done edge: set rd_addr=start_addr; pulse rd_load for one cycle; set ptr=start_addr+1 (with wrap).
REQ-021 DATA read, each later byte_done: set rd_addr=ptr; pulse rd_load; advance ptr. serial_in SHALL be ignored during read.
REQ-022 ptr advance SHALL be ptr==MAX_ADDR ? FIRST_ADDR : ptr+1, in 8-bit unsigned arithmetic.
REQ-023 wr_strobe and rd_load SHALL never both be high in the same cycle.
REQ-024 A partial byte (fewer than 8 bits) SHALL produce no strobe.
REQ-025 wr_addr, wr_data and rd_addr SHALL hold their values between strobes.
REQ-026 A frame SHALL end only by rstn; DATA SHALL continue auto-incrementing indefinitely.

Reset
REQ-027 rstn low SHALL asynchronously clear state to ADDR and clear the bit counter, ptr and rw.
REQ-028 rstn low SHALL clear wr_addr, wr_data, rd_addr, wr_strobe, rd_load, msg_flag and addr_err to 0.
REQ-029 Reset mid-byte or mid-strobe SHALL abort the byte and deassert strobes immediately; no write completes.
REQ-030 After rstn release, the first posedge SHALL sample address bit 7.

Structure
REQ-031 Package spi_ctrl_pkg SHALL hold the state enum, FIRST_ADDR/MAX_ADDR defaults, and the RW_WRITE=1 constant.
REQ-032 Sub-module spi_byte_shifter SHALL hold the 8-bit shift register and bit counter, outputting byte[7:0] and byte_done.
REQ-033 spi_frame_ctrl SHALL hold the FSM, ptr and strobe registers.

Verification
REQ-034 Write burst: send 0x84, 0xA5, 0x3C -> wr_strobe at wr_addr=4/wr_data=0xA5, then 5/0x3C; msg_flag=1 from the 8th bit onward.
REQ-035 Wrap: send 0xBB (write, addr 59), 0x11, 0x22 -> writes at 59 then 1; no strobe at addr 0 or 60.
REQ-036 Read: send 0x02 then 16 clocks -> rd_load with rd_addr=2 at the address byte_done, then 3, then 4; wr_strobe stays 0 throughout.
REQ-037 Bad address: send 0x80, then 0xFF -> addr_err=1, msg_flag=0, no strobes until reset; same for 0x3C (addr 60).
REQ-038 Reset mid-byte: write 0x85, 4 data bits, pulse rstn -> all outputs 0; a new frame 0x81, 0x55 writes 0x55 to addr 1.
REQ-039 Every scenario SHALL assert one-cycle strobe width and rd_load/wr_strobe mutual exclusion continuously.
